emd_sift_stage: RTL

Sifting stage of the EMD datapath, directly downstream of the 30-cycle input delay line. Takes the delayed input sample and the time-aligned upper/lower envelope samples, forms the mean envelope, subtracts it to produce the candidate IMF sample h, and accumulates per-frame magnitude sums. Each frame ends with a registered stop decision that the sifting controller uses to accept the IMF or iterate again.

---
 rtl/emd_sift_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/emd_sift_stage.sv
// EMD sifting stage: mean envelope, h = x - mean, per-frame |h|/|mean| sums and stop decision.
// Build option: define SIFT_SAT_EN to saturate h_out instead of two's complement wrap.
module emd_sift_stage #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 256,
    parameter int THR_SHIFT = 5,
    parameter int AW        = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] Xin_DEALY,
    input  logic [DW-1:0] env_up,
    input  logic [DW-1:0] env_lo,
    input  logic          in_valid,
    input  logic          sync,
    output logic [DW-1:0] h_out,
    output logic          h_valid,
    output logic [DW-1:0] mean_out,
    output logic          frame_done,
    output logic          stop_flag,
    output logic [AW-1:0] acc_h,
    output logic [AW-1:0] acc_m
);

    localparam int CW = 16;
    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_DECIDE = 1'b1;

    logic [DW-1:0] x_q, mean_q, mean_d, h_w, habs_w, mabs_w;
    logic [DW-1:0] h_q, mean_out_q;
    logic          v1_q, h_valid_q;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] run_h_q, run_h_d, run_m_q, run_m_d;
    logic [AW-1:0] acc_h_q, acc_h_d, acc_m_q, acc_m_d;
    logic          frame_done_q, frame_done_d, stop_q, stop_d;

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [DW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {{(AW+1-DW){1'b0}}, b};
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
    endfunction

    // floor((a+b)/2) without a wider adder: halves plus the carry of both LSBs
    assign mean_d = {env_up[DW-1], env_up[DW-1:1]} + {env_lo[DW-1], env_lo[DW-1:1]}
                  + {{(DW-1){1'b0}}, env_up[0] & env_lo[0]};

`ifdef SIFT_SAT_EN
    logic [DW:0] diff_w;
    assign diff_w = {x_q[DW-1], x_q} - {mean_q[DW-1], mean_q};
    always_comb begin
        if (diff_w[DW] != diff_w[DW-1])
            h_w = diff_w[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            h_w = diff_w[DW-1:0];
    end
`else
    assign h_w = x_q - mean_q;
`endif

    assign habs_w = h_w[DW-1]    ? (~h_w + 1'b1)    : h_w;
    assign mabs_w = mean_q[DW-1] ? (~mean_q + 1'b1) : mean_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_h_d      = run_h_q;
        run_m_d      = run_m_q;
        acc_h_d      = acc_h_q;
        acc_m_d      = acc_m_q;
        stop_d       = stop_q;
        frame_done_d = 1'b0;
        if (state_q == ST_DECIDE) begin
            acc_h_d      = run_h_q;
            acc_m_d      = run_m_q;
            stop_d       = (run_m_q <= (run_h_q >> THR_SHIFT));
            frame_done_d = 1'b1;
        end
        // decision cycle and sync both open a fresh frame with the concurrent sample
        if (state_q == ST_DECIDE || sync) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            run_h_d = '0;
            run_m_d = '0;
            if (v1_q) begin
                cnt_d   = CW'(1);
                run_h_d = sat_add('0, habs_w);
                run_m_d = sat_add('0, mabs_w);
            end
        end else if (v1_q) begin
            run_h_d = sat_add(run_h_q, habs_w);
            run_m_d = sat_add(run_m_q, mabs_w);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(FRAME_LEN - 1))
                state_d = ST_DECIDE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q          <= '0;
            mean_q       <= '0;
            v1_q         <= 1'b0;
            h_q          <= '0;
            mean_out_q   <= '0;
            h_valid_q    <= 1'b0;
            state_q      <= ST_ACCUM;
            cnt_q        <= '0;
            run_h_q      <= '0;
            run_m_q      <= '0;
            acc_h_q      <= '0;
            acc_m_q      <= '0;
            stop_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= Xin_DEALY;
            mean_q       <= mean_d;
            v1_q         <= in_valid;
            h_valid_q    <= v1_q;
            if (v1_q) begin
                h_q        <= h_w;
                mean_out_q <= mean_q;
            end
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_h_q      <= run_h_d;
            run_m_q      <= run_m_d;
            acc_h_q      <= acc_h_d;
            acc_m_q      <= acc_m_d;
            stop_q       <= stop_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign h_out      = h_q;
    assign h_valid    = h_valid_q;
    assign mean_out   = mean_out_q;
    assign frame_done = frame_done_q;
    assign stop_flag  = stop_q;
    assign acc_h      = acc_h_q;
    assign acc_m      = acc_m_q;

endmodule
